// File: rtl/fpga_cfg_pkg.sv
// Shared types and default sizes for the FPGA configuration-chain loader.
package fpga_cfg_pkg;
  localparam int DEF_WORD_W    = 32;
  localparam int DEF_CHAIN_LEN = 4096;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, SET, DONE} state_t;
endpackage

// File: rtl/cfg_piso.sv
// Parallel-in serial-out word register; emits bit 0 first, shifting right.
module cfg_piso #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] din,
  output logic              dout
);
  logic [WORD_W-1:0] shreg;

  always_ff @(posedge clk) begin
    if (!rst)       shreg <= '0;
    else if (load)  shreg <= din;
    else if (shift) shreg <= shreg >> 1;
  end

  assign dout = shreg[0];
endmodule

// File: rtl/fpga_cfg_loader.sv
// Streams bitstream words serially into the fabric configuration chain, then latches it.
// Optional readback of the chain's shift_out is enabled by defining FPGA_CFG_READBACK_EN.
module fpga_cfg_loader import fpga_cfg_pkg::*; #(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int CNT_W     = $clog2(CHAIN_LEN+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              cen,
  output logic              cfg_shift,
  output logic              cset,
  input  logic              chain_in,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);
  localparam int WC_W = $clog2(WORD_W+1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [WC_W-1:0]   wcnt;
  logic              hs, last_chain, last_word, piso_out;

  assign hs         = word_valid && word_ready;
  assign last_chain = (cnt == CNT_W'(CHAIN_LEN-1));
  assign last_word  = (wcnt == WC_W'(WORD_W-1));

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // abort gates the commit-type outputs so a cancelled load never latches
  always_comb begin
    state_n    = state;
    word_ready = 1'b0;
    cen        = 1'b0;
    cset       = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_n = LOAD;
      end
      LOAD: begin
        word_ready = !abort;
        if (abort)           state_n = IDLE;
        else if (word_valid) state_n = SHIFT;
      end
      SHIFT: begin
        cen = 1'b1;
        if (abort)           state_n = IDLE;
        else if (last_chain) state_n = SET;
        else if (last_word)  state_n = LOAD;
      end
      SET: begin
        cset    = !abort;
        state_n = abort ? IDLE : DONE;
      end
      DONE: begin
        done    = !abort;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt  <= '0;
      wcnt <= '0;
    end else begin
      if (state == IDLE && start) cnt <= '0;
      else if (cen)               cnt <= cnt + CNT_W'(1);
      if (hs)       wcnt <= '0;
      else if (cen) wcnt <= wcnt + WC_W'(1);
    end
  end

  cfg_piso #(.WORD_W(WORD_W)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (hs),
    .shift (cen),
    .din   (word_data),
    .dout  (piso_out)
  );

  assign cfg_shift = cen & piso_out;

`ifdef FPGA_CFG_READBACK_EN
  // readback bit position tracks the outgoing bit position within the word
  logic [WORD_W-1:0] rb_acc, rb_next;
  logic              rb_emit;

  assign rb_next = rb_acc | (WORD_W'(chain_in) << wcnt);
  assign rb_emit = cen && (last_word || last_chain);

  always_ff @(posedge clk) begin
    if (!rst) begin
      rb_acc   <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= rb_emit;
      if (state == IDLE) rb_acc <= '0;
      else if (cen)      rb_acc <= rb_emit ? '0 : rb_next;
      if (rb_emit) rb_data <= rb_next;
    end
  end
`else
  logic unused_chain_in;
  assign unused_chain_in = chain_in;
  assign rb_data  = '0;
  assign rb_valid = 1'b0;
`endif
endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed bench for fpga_cfg_loader (WORD_W=32, CHAIN_LEN=40) with a queue-based reference model.
module tb_fpga_cfg_loader;
  localparam int WW = 32;
  localparam int CL = 40;
  localparam logic [31:0] W0 = 32'hA5A50001;
  localparam logic [31:0] W1 = 32'h000000FF;
`ifdef FPGA_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, abort, word_valid;
  logic [WW-1:0] word_data;
  logic          word_ready, cen, cfg_shift, cset, chain_in, busy, done, rb_valid;
  logic [WW-1:0] rb_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fpga_cfg_loader #(.WORD_W(WW), .CHAIN_LEN(CL)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
    .cen(cen), .cfg_shift(cfg_shift), .cset(cset), .chain_in(chain_in),
    .busy(busy), .done(done), .rb_data(rb_data), .rb_valid(rb_valid)
  );

  // fabric model: 40-bit chain, shift_out from the far end
  logic [CL-1:0] chain = '0;
  always @(posedge clk) if (cen) chain <= {chain[CL-2:0], cfg_shift};
  assign chain_in = chain[CL-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // reference model: bits waiting to be shifted live in a queue
  bit          q[$];
  bit          armed = 1'b0, active, e_cset, e_done, e_rbv;
  int          queued, shifted, rb_n, cyc = 0;
  logic [31:0] e_rbd, rb_acc;
  // observations of the DUT for the literal checks
  int          ld_cen, cset_cyc, done_cyc, done_cnt;
  int          cen_cyc[64];
  logic        first_bit;
  logic [7:0]  last8;
  logic [31:0] rb_q[$];

  always @(negedge clk) begin
    bit m_cen, m_idle, n_cset, n_done, n_rbv, b;
    int n;
    cyc++;
    if (armed) begin
      m_cen  = active && q.size() > 0;
      m_idle = !(active || e_cset || e_done);
      chk("word_ready", word_ready, active && q.size() == 0 && !abort);
      chk("busy", busy, !m_idle);
      chk("cen", cen, m_cen);
      chk("cfg_shift", cfg_shift, m_cen ? q[0] : 1'b0);
      chk("cset", cset, e_cset && !abort);
      chk("done", done, e_done && !abort);
      chk("rb_valid", rb_valid, e_rbv);
      chk("rb_data", rb_data, e_rbd);
      if (cen) begin
        if (ld_cen == 0) first_bit = cfg_shift;
        if (ld_cen < 64) cen_cyc[ld_cen] = cyc;
        last8 = {last8[6:0], cfg_shift};
        ld_cen++;
      end
      if (cset) cset_cyc = cyc;
      if (done) begin done_cyc = cyc; done_cnt++; end
      if (rb_valid) rb_q.push_back(rb_data);
    end
    if (!rst) begin
      armed = 1'b1; active = 0; e_cset = 0; e_done = 0; e_rbv = 0; e_rbd = '0;
      q.delete(); queued = 0; shifted = 0; rb_n = 0; rb_acc = '0;
    end else if (armed) begin
      n_cset = 0; n_done = 0; n_rbv = 0;
      if (m_cen) begin
        b = q.pop_front();
        shifted++;
        if (RB) begin
          rb_acc[rb_n] = chain_in;
          rb_n++;
          if (rb_n == WW || shifted == CL) begin
            n_rbv = 1; e_rbd = rb_acc; rb_acc = '0; rb_n = 0;
          end
        end
      end
      if (m_idle) begin
        if (start) begin
          active = 1; shifted = 0; queued = 0; rb_acc = '0; rb_n = 0;
          ld_cen = 0; cset_cyc = -1; done_cyc = -1; done_cnt = 0; last8 = '0; rb_q.delete();
        end
      end else if (abort) begin
        active = 0;
        q.delete();
      end else begin
        if (e_cset) n_done = 1;
        if (active && !m_cen && word_valid) begin
          n = (CL - queued < WW) ? CL - queued : WW;
          for (int i = 0; i < n; i++) q.push_back(word_data[i]);
          queued += n;
        end
        if (m_cen && shifted == CL) begin active = 0; n_cset = 1; end
      end
      e_cset = n_cset; e_done = n_done; e_rbv = n_rbv;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // returns #1 after the edge that completes a handshake
  task automatic wait_hs();
    int n = 0;
    do begin @(negedge clk); n++; end while (!(word_ready && word_valid) && n < 300);
    chk("hs_wait_bound", n < 300, 1'b1);
    tick();
  endtask

  task automatic wait_done();
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 300);
    chk("done_wait_bound", n < 300, 1'b1);
    tick();
  endtask

  task automatic full_load();
    word_valid = 1'b1; word_data = W0;
    pulse_start();
    wait_hs();
    word_data = W1;
    wait_hs();
    word_valid = 1'b0;
    wait_done();
  endtask

  initial begin
    int n;
    rst = 1'b0; start = 0; abort = 0; word_valid = 0; word_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_cen", cen, 1'b0);
    chk("rst_rb_data", rb_data, '0);

    // back-to-back words
    full_load();
    chk("s1_cen_count", ld_cen, 40);
    chk("s1_first_bit", first_bit, 1'b1);
    chk("s1_last8", last8, 8'hFF);
    chk("s1_cset_lat", cset_cyc - cen_cyc[39], 1);
    chk("s1_done_lat", done_cyc - cset_cyc, 1);
    chk("s1_word_gap", cen_cyc[32] - cen_cyc[31], 2);
    tick();

    // 5-cycle stall between words; second pass of the chain
    word_valid = 1'b1; word_data = W0;
    pulse_start();
    wait_hs();
    word_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!word_ready && n < 300);
    chk("stall_wait_bound", n < 300, 1'b1);
    repeat (5) @(posedge clk);
    #1 word_valid = 1'b1; word_data = W1;
    wait_hs();
    word_valid = 1'b0;
    wait_done();
    chk("s2_cen_count", ld_cen, 40);
    chk("s2_word_gap", cen_cyc[32] - cen_cyc[31], 7);
    chk("s2_last8", last8, 8'hFF);
    if (RB) begin
      chk("s2_rb_count", rb_q.size(), 2);
      if (rb_q.size() == 2) begin
        chk("s2_rb_word0", rb_q[0], W0);
        chk("s2_rb_word1", rb_q[1], W1);
      end
    end
    tick();

    // abort at bit 10, then a clean reload
    word_valid = 1'b1; word_data = W0;
    pulse_start();
    wait_hs();
    word_valid = 1'b0;
    repeat (10) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_bits", ld_cen, 11);
    repeat (3) tick();
    chk("abort_no_cset", cset_cyc, -1);
    chk("abort_no_done", done_cnt, 0);
    full_load();
    chk("reload_cen_count", ld_cen, 40);
    chk("reload_first_bit", first_bit, 1'b1);
    chk("reload_done_cnt", done_cnt, 1);
    tick();

    // reset at bit 20
    word_valid = 1'b1; word_data = W0;
    pulse_start();
    wait_hs();
    word_valid = 1'b0;
    repeat (20) tick();
    rst = 1'b0; tick();
    chk("rstmid_outs", {word_ready, cen, cfg_shift, cset, busy, done, rb_valid}, 7'b0);
    chk("rstmid_rb_data", rb_data, '0);
    rst = 1'b1;
    repeat (3) tick();
    chk("rstmid_no_cset", cset_cyc, -1);

    // start during SHIFT is ignored
    word_valid = 1'b1; word_data = W0;
    pulse_start();
    wait_hs();
    word_data = W1;
    repeat (3) tick();
    pulse_start();
    wait_hs();
    word_valid = 1'b0;
    wait_done();
    chk("s6_cen_count", ld_cen, 40);
    chk("s6_done_cnt", done_cnt, 1);
    repeat (3) tick();
    chk("s6_idle", busy, 1'b0);

    // abort wins over a simultaneous handshake
    pulse_start();
    word_valid = 1'b1; word_data = W1; abort = 1'b1;
    tick();
    abort = 1'b0; word_valid = 1'b0;
    chk("s7_busy", busy, 1'b0);
    repeat (2) tick();
    chk("s7_no_shift", ld_cen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
